// File: rtl/crcu_pkg.sv
// Shared types and defaults for the clock/reset control unit monitors.
package crcu_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } mon_state_e;

endpackage

// File: rtl/clk_edge_det.sv
// Registered sampler for a clock-synchronous toggling signal; emits rise/fall pulses.
module clk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;

  always_ff @(posedge clk) begin
    if (rst || clr) sig_d <= 1'b0;
    else            sig_d <= sig;
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/clk_div_mon.sv
// Divided-clock monitor: measures high phase and period, checks against N, tracks lock/timeout.
//
// state     | meaning
// IDLE      | disabled or N=0; nothing counted
// WAIT_RISE | armed, waiting for the first rise to start a period
// HIGH      | counting the high phase
// LOW       | counting the low phase; next rise completes a measurement
module clk_div_mon
  import crcu_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic             i_clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_mon_clk,
  input  logic [CNT_W-1:0] i_exp_half,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W:0]   o_period_cnt,
  output logic             o_meas_vld,
  output logic             o_err_duty,
  output logic             o_err_period,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int LK_W = $clog2(LOCK_CNT + 1);
  localparam int DW   = CNT_W + 2;
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
  localparam logic [LK_W-1:0]      LOCK_FULL = LK_W'(LOCK_CNT);
  localparam logic signed [DW-1:0] TOL_S     = DW'(TOL);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic signed [DW-1:0] abs_s(input logic signed [DW-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

  mon_state_e state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d, exp_q, exp_d;
  logic [LK_W-1:0]  good_q, good_d;
  logic             rise, fall;

  logic [CNT_W-1:0] high_d;
  logic [CNT_W:0]   period_d;
  logic             vld_d, err_duty_d, err_per_d, locked_d, timeout_d;

  logic [CNT_W:0]          period_sum;
  logic signed [DW-1:0]    d_high, d_per, limit;
  logic                    duty_bad, per_bad, hcnt_over, lcnt_over;

  clk_edge_det u_edge (
    .clk  (i_clk),
    .rst  (rst),
    .clr  (~i_en),
    .sig  (i_mon_clk),
    .rise (rise),
    .fall (fall)
  );

  // Deviations are evaluated against the N latched at the start of the period.
  assign period_sum = {1'b0, hcnt_q} + {1'b0, lcnt_q};
  assign d_high     = $signed({2'b00, hcnt_q}) - $signed({2'b00, exp_q});
  assign d_per      = $signed({1'b0, period_sum}) - $signed({1'b0, exp_q, 1'b0});
  assign limit      = $signed({1'b0, exp_q, 1'b0}) + TOL_S;
  assign duty_bad   = abs_s(d_high) > TOL_S;
  assign per_bad    = abs_s(d_per) > TOL_S;
  assign hcnt_over  = $signed({2'b00, hcnt_q}) > limit;
  assign lcnt_over  = $signed({2'b00, lcnt_q}) > limit;

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    lcnt_d     = lcnt_q;
    exp_d      = exp_q;
    good_d     = good_q;
    high_d     = o_high_cnt;
    period_d   = o_period_cnt;
    vld_d      = 1'b0;
    err_duty_d = o_err_duty;
    err_per_d  = o_err_period;
    locked_d   = o_locked;
    timeout_d  = o_timeout;

    if (i_exp_half == '0) begin
      state_d  = IDLE;
      hcnt_d   = '0;
      lcnt_d   = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
          hcnt_d  = '0;
          lcnt_d  = '0;
          exp_d   = i_exp_half;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_d = HIGH;
            hcnt_d  = CNT_W'(1);
            lcnt_d  = '0;
            exp_d   = i_exp_half;
          end else if (fall) begin
            lcnt_d = CNT_W'(1);
          end else if (lcnt_over) begin
            hcnt_d    = '0;
            lcnt_d    = '0;
            good_d    = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
          end else begin
            lcnt_d = sat_inc(lcnt_q);
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            lcnt_d  = CNT_W'(1);
          end else if (hcnt_over) begin
            state_d   = WAIT_RISE;
            hcnt_d    = '0;
            lcnt_d    = '0;
            good_d    = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
          end else begin
            hcnt_d = sat_inc(hcnt_q);
          end
        end
        LOW: begin
          if (rise) begin
            state_d    = HIGH;
            high_d     = hcnt_q;
            period_d   = period_sum;
            vld_d      = 1'b1;
            err_duty_d = duty_bad;
            err_per_d  = per_bad;
            if (duty_bad || per_bad)   good_d = '0;
            else if (good_q != LOCK_FULL) good_d = good_q + LK_W'(1);
            locked_d   = (good_d == LOCK_FULL);
            hcnt_d     = CNT_W'(1);
            lcnt_d     = '0;
            exp_d      = i_exp_half;
          end else if (lcnt_over) begin
            state_d   = WAIT_RISE;
            hcnt_d    = '0;
            lcnt_d    = '0;
            good_d    = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
          end else begin
            lcnt_d = sat_inc(lcnt_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Disable has priority over every event, same as reset.
  always_ff @(posedge i_clk) begin
    if (rst || !i_en) begin
      state_q      <= IDLE;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      exp_q        <= '0;
      good_q       <= '0;
      o_high_cnt   <= '0;
      o_period_cnt <= '0;
      o_meas_vld   <= 1'b0;
      o_err_duty   <= 1'b0;
      o_err_period <= 1'b0;
      o_locked     <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      exp_q        <= exp_d;
      good_q       <= good_d;
      o_high_cnt   <= high_d;
      o_period_cnt <= period_d;
      o_meas_vld   <= vld_d;
      o_err_duty   <= err_duty_d;
      o_err_period <= err_per_d;
      o_locked     <= locked_d;
      o_timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_clk_div_mon.sv
// Scoreboard bench for clk_div_mon: two instances (TOL=0 and TOL=1) driven with the same divided clock.
module tb_clk_div_mon;

  localparam int CW = 16;
  localparam int LK = 4;

  logic          clk = 1'b0;
  logic          rst, en, mon;
  logic [CW-1:0] exp_half;

  logic [CW-1:0] hc0, hc1;
  logic [CW:0]   pc0, pc1;
  logic          vld0, vld1, ed0, ed1, ep0, ep1, lk0, lk1, to0, to1;

  clk_div_mon #(.CNT_W(CW), .TOL(0), .LOCK_CNT(LK)) u0 (
    .i_clk(clk), .rst(rst), .i_en(en), .i_mon_clk(mon), .i_exp_half(exp_half),
    .o_high_cnt(hc0), .o_period_cnt(pc0), .o_meas_vld(vld0), .o_err_duty(ed0),
    .o_err_period(ep0), .o_locked(lk0), .o_timeout(to0));

  clk_div_mon #(.CNT_W(CW), .TOL(1), .LOCK_CNT(LK)) u1 (
    .i_clk(clk), .rst(rst), .i_en(en), .i_mon_clk(mon), .i_exp_half(exp_half),
    .o_high_cnt(hc1), .o_period_cnt(pc1), .o_meas_vld(vld1), .o_err_duty(ed1),
    .o_err_period(ep1), .o_locked(lk1), .o_timeout(to1));

  always #5 clk = ~clk;

  typedef struct {
    int high;
    int period;
    bit ed;
    bit ep;
    bit lk;
  } meas_t;

  meas_t q0[$], q1[$];
  meas_t e0, e1;

  int n_checks = 0;
  int n_errors = 0;

  int good[2];
  bit have_prev;
  int ph, pl, pn;

  task automatic check_val(input string tag, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, expv, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic push_meas(input int h, input int l, input int n);
    meas_t m;
    for (int i = 0; i < 2; i++) begin
      m.high   = h;
      m.period = h + l;
      m.ed     = iabs(h - n) > i;
      m.ep     = iabs(h + l - 2 * n) > i;
      if (m.ed || m.ep)  good[i] = 0;
      else if (good[i] < LK) good[i]++;
      m.lk = (good[i] == LK);
      if (i == 0) q0.push_back(m);
      else        q1.push_back(m);
    end
  endtask

  task automatic clear_model();
    have_prev = 1'b0;
    good[0]   = 0;
    good[1]   = 0;
  endtask

  task automatic drive_period(input int h, input int l, input int chg_after = -1, input int new_exp = 0);
    if (have_prev) push_meas(ph, pl, pn);
    ph = h; pl = l; pn = int'(exp_half); have_prev = 1'b1;
    for (int k = 0; k < h; k++) begin
      if (k == chg_after) exp_half = CW'(new_exp);
      mon = 1'b1;
      @(negedge clk);
    end
    for (int k = 0; k < l; k++) begin
      mon = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic idle_low(input int n);
    for (int k = 0; k < n; k++) begin
      mon = 1'b0;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (vld0 === 1'b1) begin
      if (q0.size() == 0) check_val("u0_unexpected_vld", 1, 0);
      else begin
        e0 = q0.pop_front();
        check_val("u0_high", int'(hc0), e0.high);
        check_val("u0_period", int'(pc0), e0.period);
        check_val("u0_err_duty", int'(ed0), int'(e0.ed));
        check_val("u0_err_period", int'(ep0), int'(e0.ep));
        check_val("u0_locked", int'(lk0), int'(e0.lk));
      end
    end
    if (vld1 === 1'b1) begin
      if (q1.size() == 0) check_val("u1_unexpected_vld", 1, 0);
      else begin
        e1 = q1.pop_front();
        check_val("u1_high", int'(hc1), e1.high);
        check_val("u1_period", int'(pc1), e1.period);
        check_val("u1_err_duty", int'(ed1), int'(e1.ed));
        check_val("u1_err_period", int'(ep1), int'(e1.ep));
        check_val("u1_locked", int'(lk1), int'(e1.lk));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; mon = 1'b0; exp_half = CW'(4);
    clear_model();
    repeat (3) @(negedge clk);
    check_val("rst_vld", int'(vld0), 0);
    check_val("rst_high", int'(hc0), 0);
    check_val("rst_period", int'(pc0), 0);
    check_val("rst_locked", int'(lk0), 0);
    check_val("rst_timeout", int'(to0), 0);
    rst = 1'b0;
    idle_low(2);

    // ideal N=4 divider: lock on the 4th measurement
    repeat (6) drive_period(4, 4);
    check_val("lock_after_ideal", int'(lk0), 1);

    // one distorted period, then recovery
    drive_period(5, 3);
    repeat (5) drive_period(4, 4);

    // expected half changes mid-high while the divider moves to N=6
    drive_period(6, 6, 2, 6);
    repeat (3) drive_period(6, 6);
    exp_half = CW'(4);

    // tolerance boundary for the TOL=1 instance
    drive_period(5, 4);
    drive_period(5, 5);
    drive_period(4, 4);
    drive_period(4, 4);

    // stuck-high clock
    push_meas(ph, pl, pn);
    have_prev = 1'b0;
    for (int k = 0; k < 12; k++) begin
      mon = 1'b1;
      @(negedge clk);
      if (k == 8) check_val("to0_before_limit", int'(to0), 0);
      if (k == 9) begin
        check_val("to0_at_limit", int'(to0), 1);
        check_val("lk0_cleared_by_to", int'(lk0), 0);
        check_val("to1_before_limit", int'(to1), 0);
      end
      if (k == 10) check_val("to1_at_limit", int'(to1), 1);
    end
    good[0] = 0; good[1] = 0;
    idle_low(3);
    repeat (3) drive_period(4, 4);
    check_val("to0_sticky", int'(to0), 1);
    check_val("to1_sticky", int'(to1), 1);

    // disable clears timeout and outputs
    mon = 1'b0; en = 1'b0;
    @(negedge clk);
    check_val("dis_to0", int'(to0), 0);
    check_val("dis_to1", int'(to1), 0);
    check_val("dis_high", int'(hc0), 0);
    check_val("dis_locked", int'(lk1), 0);
    en = 1'b1;
    clear_model();
    idle_low(2);

    // reset in the middle of a low phase
    repeat (2) drive_period(4, 4);
    push_meas(ph, pl, pn);
    have_prev = 1'b0;
    for (int k = 0; k < 4; k++) begin mon = 1'b1; @(negedge clk); end
    for (int k = 0; k < 2; k++) begin mon = 1'b0; @(negedge clk); end
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_vld", int'(vld0), 0);
    check_val("mid_rst_high", int'(hc0), 0);
    check_val("mid_rst_period", int'(pc0), 0);
    check_val("mid_rst_err", int'(ed0 | ep0), 0);
    check_val("mid_rst_period1", int'(pc1), 0);
    rst = 1'b0;
    clear_model();
    idle_low(2);
    repeat (3) drive_period(4, 4);

    idle_low(3);
    check_val("q0_drained", q0.size(), 0);
    check_val("q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
